// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared defaults and helpers for the UART receive buffer:
//             default data width and FIFO pointer/count width.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int DBIT_DEFAULT = 8;

  // Pointer and count width: index bits plus one wrap bit, which also lets
  // the count hold the value DEPTH itself.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : uart_fifo_mem
//  Purpose  : Simple dual-port register array, WIDTH x DEPTH.
//             Synchronous write, asynchronous (combinational) read.
//             The array has no reset; contents are undefined until written.
//  Ports    : clk      - write clock
//             wr_en    - write strobe
//             wr_addr  - write index
//             wr_data  - write word
//             rd_addr  - read index
//             rd_data  - word at rd_addr (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module uart_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule : uart_fifo_mem
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : Receive buffer behind the UART receiver. Captures each byte on
//             the receiver's done pulse into a DEPTH-entry FIFO and presents
//             it first-word-fall-through to the host with valid/ready.
//             Reports occupancy, a registered almost_full and a sticky
//             overflow flag.
//  Option   : UART_RX_FIFO_ERR_TAG_EN - when defined, each entry carries the
//             frame-error bit and errored bytes are buffered; otherwise
//             errored bytes are discarded and rd_frame_err is tied low.
//  Ports    : clk, reset_n (async, active low)
//             rx_data/rx_done/rx_frame_error - receiver side
//             rd_data/rd_frame_err/rd_valid/rd_ready - host side (FWFT)
//             count, almost_full, overflow, overflow_clr - status
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DBIT  = DBIT_DEFAULT,
  parameter int DEPTH = 16,
  parameter int AFULL = 12
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [DBIT-1:0]            rx_data,
  input  logic                       rx_done,
  input  logic                       rx_frame_error,
  output logic [DBIT-1:0]            rd_data,
  output logic                       rd_frame_err,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full,
  output logic                       overflow,
  input  logic                       overflow_clr
);

  localparam int PW = fifo_ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] C_AFULL = PW'(AFULL);

`ifdef UART_RX_FIFO_ERR_TAG_EN
  localparam int EW = DBIT + 1;
`else
  localparam int EW = DBIT;
`endif

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_count;
  logic          r_almost_full;
  logic          r_overflow;

  logic          w_empty;
  logic          w_full;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic [PW-1:0] w_count_next;
  logic [EW-1:0] w_wr_entry;
  logic [EW-1:0] w_rd_entry;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

`ifdef UART_RX_FIFO_ERR_TAG_EN
  // Errored bytes are stored like good ones, tag kept in the top bit.
  assign w_accept   = 1'b1;
  assign w_wr_entry = {rx_frame_error, rx_data};
`else
  // Errored bytes never reach the FIFO and are not counted as drops.
  assign w_accept   = ~rx_frame_error;
  assign w_wr_entry = rx_data;
`endif

  assign w_pop  = ~w_empty & rd_ready;
  // A full FIFO still accepts when a pop frees a slot on the same edge.
  assign w_push = rx_done & w_accept & (~w_full | w_pop);
  assign w_drop = rx_done & w_accept & w_full & ~w_pop;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + PW'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count       <= w_count_next;
      // Derived from next-state count so it lines up with count exactly.
      r_almost_full <= (w_count_next >= C_AFULL);
      // A new drop wins over a same-cycle clear.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (overflow_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  uart_fifo_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_push),
    .wr_addr (r_wr_ptr[AW-1:0]),
    .wr_data (w_wr_entry),
    .rd_addr (r_rd_ptr[AW-1:0]),
    .rd_data (w_rd_entry)
  );

  // Storage is not reset, so the head is masked to zero while empty.
  assign rd_valid = ~w_empty;
  assign rd_data  = rd_valid ? w_rd_entry[DBIT-1:0] : '0;

`ifdef UART_RX_FIFO_ERR_TAG_EN
  assign rd_frame_err = rd_valid & w_rd_entry[DBIT];
`else
  assign rd_frame_err = 1'b0;
`endif

  assign count       = r_count;
  assign almost_full = r_almost_full;
  assign overflow    = r_overflow;

endmodule : uart_rx_fifo
`default_nettype wire
